// File: rtl/wave_pkg.sv
// Shared types and helpers for the waveform capture/display pair.
// The package holds the capture FSM state type, the RAM geometry and
// the sample-to-RAM quantiser used by the writer side.
package wave_pkg;

    typedef enum logic [1:0] {CAP_ARMED, CAP_ACTIVE, CAP_WAIT} cap_state_t;

    localparam int SAMPLE_W   = 16;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 9;

    // Signed 16-bit sample -> 8-bit offset binary (top byte with the sign bit flipped).
    function automatic logic [7:0] to_offset8(input logic signed [15:0] s);
        return 8'({~s[15], s[14:0]} >> 8);
    endfunction

endpackage

// File: rtl/wave_capture_ctrl_if.sv
// Signal bundle between the capture controller and its environment:
// the audio sample stream, the display idle flag, the RAM write port,
// the buffer-select output and status/debug outputs.
//
// Handshake: new_sample_ready is a one-cycle strobe with no back-pressure;
// new_sample_in is valid only in that cycle. write_enable is a one-cycle
// strobe and write_address/write_sample are valid only while it is high.
import wave_pkg::*;

interface wave_capture_ctrl_if;
    logic                  new_sample_ready;
    logic [SAMPLE_W-1:0]   new_sample_in;
    logic                  wave_display_idle;
    logic [RAM_ADDR_W-1:0] write_address;
    logic                  write_enable;
    logic [RAM_DATA_W-1:0] write_sample;
    logic                  read_index;
    logic                  armed;
    cap_state_t            state;

    // Controller side.
    modport master (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_enable, write_sample, read_index, armed, state
    );

    // Environment side (sample source, display, RAM).
    modport slave (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index, armed, state
    );
endinterface

// File: rtl/wave_trigger.sv
// Rising zero-crossing detector for the capture controller.
// Holds the previous-sample sign and, when WAVE_CAPTURE_TIMEOUT_EN is
// defined, a counter of samples seen while armed that forces a trigger
// after TIMEOUT samples.
import wave_pkg::*;

module wave_trigger
`ifdef WAVE_CAPTURE_TIMEOUT_EN
    #(parameter int TIMEOUT = 1024)
`endif
    (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample_valid,
    input  logic sample_neg,
`ifdef WAVE_CAPTURE_TIMEOUT_EN
    input  logic armed,
`endif
    output logic trigger
);

    logic prev_neg;
    logic crossing;

    // A zero sample has sign bit 0, so it counts as non-negative here.
    assign crossing = sample_valid && prev_neg && !sample_neg;

    // Sign history; a clear (buffer flip) wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev_neg <= 1'b0;
        end else if (sample_valid) begin
            prev_neg <= sample_neg;
        end
    end

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    assign timeout_hit = sample_valid && armed && (to_cnt == TW'(TIMEOUT - 1));
    assign trigger     = crossing || timeout_hit;

    // Samples seen while armed; held at zero outside ARMED so it restarts on entry.
    always_ff @(posedge clk) begin
        if (rst || clr || !armed) begin
            to_cnt <= '0;
        end else if (sample_valid) begin
            to_cnt <= timeout_hit ? '0 : to_cnt + 1'b1;
        end
    end
`else
    assign trigger = crossing;
`endif

endmodule

// File: rtl/wave_capture_ctrl.sv
// Writer side of the double-buffered waveform RAM.
// Arms on a rising zero crossing, writes NUM_SAMPLES quantised samples
// into the half not being displayed, then waits for display idle and
// flips read_index. Optional forced trigger: WAVE_CAPTURE_TIMEOUT_EN.
import wave_pkg::*;

module wave_capture_ctrl #(
    parameter int NUM_SAMPLES = 256
`ifdef WAVE_CAPTURE_TIMEOUT_EN
    , parameter int TIMEOUT   = 1024
`endif
) (
    input  logic                clk,
    input  logic                rst,
    wave_capture_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(NUM_SAMPLES);

    cap_state_t       state_q, state_d;
    logic [CNT_W-1:0] sample_cnt, cnt_d;
    logic             read_index_q;
    logic             do_write;
    logic             flip;
    logic             trigger;

    logic [RAM_ADDR_W-1:0] write_address_q;
    logic                  write_enable_q;
    logic [RAM_DATA_W-1:0] write_sample_q;

    wave_trigger
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        #(.TIMEOUT(TIMEOUT))
`endif
    u_trigger (
        .clk          (clk),
        .rst          (rst),
        .clr          (flip),
        .sample_valid (bus.new_sample_ready),
        .sample_neg   (bus.new_sample_in[SAMPLE_W-1]),
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        .armed        (state_q == CAP_ARMED),
`endif
        .trigger      (trigger)
    );

    // Next state, sample counter and write/flip decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = sample_cnt;
        do_write = 1'b0;
        flip     = 1'b0;
        case (state_q)
            CAP_ARMED: begin
                // sample_cnt is 0 here, so the triggering sample lands at offset 0.
                if (trigger) begin
                    do_write = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = CAP_ACTIVE;
                end
            end
            CAP_ACTIVE: begin
                if (bus.new_sample_ready) begin
                    do_write = 1'b1;
                    if (sample_cnt == CNT_W'(NUM_SAMPLES - 1)) begin
                        cnt_d   = '0;
                        state_d = CAP_WAIT;
                    end else begin
                        cnt_d = sample_cnt + 1'b1;
                    end
                end
            end
            CAP_WAIT: begin
                // Samples are dropped here; only display idle moves us on.
                if (bus.wave_display_idle) begin
                    flip    = 1'b1;
                    state_d = CAP_ARMED;
                end
            end
            default: begin
                state_d = CAP_ARMED;
            end
        endcase
    end

    // State, counter, buffer select and registered RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= CAP_ARMED;
            sample_cnt      <= '0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            state_q        <= state_d;
            sample_cnt     <= cnt_d;
            write_enable_q <= do_write;
            if (flip) begin
                read_index_q <= ~read_index_q;
            end
            if (do_write) begin
                write_address_q <= {~read_index_q, sample_cnt};
                write_sample_q  <= to_offset8(bus.new_sample_in);
            end
        end
    end

    assign bus.write_address = write_address_q;
    assign bus.write_enable  = write_enable_q;
    assign bus.write_sample  = write_sample_q;
    assign bus.read_index    = read_index_q;
    assign bus.armed         = (state_q == CAP_ARMED);
    assign bus.state         = state_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Bench for wave_capture_ctrl: directed scenarios with literal expectations,
// then randomized samples/idle/reset checked every cycle against a
// behavioural model of the capture rules.
import wave_pkg::*;

module tb_wave_capture_ctrl;

    localparam int N = 256;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TO = 4;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wave_capture_ctrl_if bus();

    wave_capture_ctrl #(
        .NUM_SAMPLES(N)
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;
    int last_addr = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The capture is described as: a buffer select bit, a count of samples
    // stored in the current capture, and whether we are capturing or
    // waiting for the display. Expected writes go into exp_q.
    logic [16:0] exp_q[$];   // {address, data}
    bit m_ri, m_prev_neg, m_capturing, m_waiting;
    int m_filled, m_tcnt;
    bit e_we, e_reset;

    task automatic model_step(input bit r, input bit v, input int s, input bit idle);
        bit trig;
        int addr, data;
        e_we    = 0;
        e_reset = 0;
        if (r) begin
            m_ri = 0; m_prev_neg = 0; m_capturing = 0; m_waiting = 0;
            m_filled = 0; m_tcnt = 0; e_reset = 1;
            exp_q.delete();
            return;
        end
        if (m_waiting) begin
            if (idle) begin
                m_ri = !m_ri; m_prev_neg = 0; m_waiting = 0; m_tcnt = 0;
            end else if (v) begin
                m_prev_neg = (s < 0);
            end
            return;
        end
        if (!v) return;
        trig = 0;
        if (!m_capturing) begin
            trig = m_prev_neg && (s >= 0);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            if (m_tcnt == TO - 1) trig = 1;
            m_tcnt = trig ? 0 : m_tcnt + 1;
`endif
            if (trig) begin
                m_capturing = 1;
                m_filled = 0;
            end
        end
        if (m_capturing) begin
            addr = (m_ri ? 0 : 256) + m_filled;
            data = (s + 32768) / 256;
            exp_q.push_back({9'(addr), 8'(data)});
            e_we = 1;
            m_filled++;
            if (m_filled == N) begin
                m_capturing = 0; m_waiting = 1; m_filled = 0;
            end
        end
        m_prev_neg = (s < 0);
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [16:0] item;
        forever begin
            @(posedge clk);
            model_step(rst, bus.new_sample_ready,
                       int'($signed(bus.new_sample_in)), bus.wave_display_idle);
            #1;
            check("write_enable", int'(bus.write_enable), int'(e_we));
            check("read_index", int'(bus.read_index), int'(m_ri));
            check("armed", int'(bus.armed), int'(!m_capturing && !m_waiting));
            if (e_reset) begin
                check("reset_address", int'(bus.write_address), 0);
                check("reset_sample", int'(bus.write_sample), 0);
            end
            if (bus.write_enable) begin
                wr_count++;
                last_addr = int'(bus.write_address);
                check("write_half_invariant",
                      int'(bus.write_address[8] != bus.read_index), 1);
            end
            if (e_we) begin
                item = exp_q.pop_front();
                if (bus.write_enable) begin
                    check("write_address", int'(bus.write_address), int'(item[16:8]));
                    check("write_sample", int'(bus.write_sample), int'(item[7:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int val);
        @(negedge clk);
        bus.new_sample_ready = 1'b1;
        bus.new_sample_in    = 16'(val);
        @(negedge clk);
        bus.new_sample_ready = 1'b0;
    endtask

    task automatic send_with_idle(input int val);
        @(negedge clk);
        bus.new_sample_ready  = 1'b1;
        bus.new_sample_in     = 16'(val);
        bus.wave_display_idle = 1'b1;
        @(negedge clk);
        bus.new_sample_ready  = 1'b0;
        bus.wave_display_idle = 1'b0;
    endtask

    task automatic idle_pulse();
        @(negedge clk);
        bus.wave_display_idle = 1'b1;
        @(negedge clk);
        bus.wave_display_idle = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values.
        check("rst_write_enable", int'(bus.write_enable), 0);
        check("rst_read_index", int'(bus.read_index), 0);
        check("rst_armed", int'(bus.armed), 1);

        // -5 then +3: only the second sample writes.
        send(-5);
        check("first_sample_no_write", int'(bus.write_enable), 0);
        wr_count = 0;
        send(3);
        check("trig_write_enable", int'(bus.write_enable), 1);
        check("trig_address", int'(bus.write_address), 'h100);
        check("trig_sample", int'(bus.write_sample), 'h80);

        // Fill the rest of the capture, then one extra sample.
        repeat (N - 1) send(rand_sample());
        check("capture_writes", wr_count, 256);
        check("capture_last_address", last_addr, 'h1FF);
        send(rand_sample());
        check("wait_no_write", int'(bus.write_enable), 0);
        check("wait_write_count", wr_count, 256);
        check("wait_state", int'(bus.state), int'(CAP_WAIT));
        check("wait_read_index", int'(bus.read_index), 0);

        // Display idle flips the buffer; next capture writes the lower half.
        idle_pulse();
        check("flip_read_index", int'(bus.read_index), 1);
        send(-1);
        send(1);
        check("flip_first_address", int'(bus.write_address), 'h000);
        check("flip_first_enable", int'(bus.write_enable), 1);

        // Abort at sample_cnt=100 with read_index=1.
        repeat (99) send(rand_sample());
        do_reset();
        check("abort_write_enable", int'(bus.write_enable), 0);
        check("abort_read_index", int'(bus.read_index), 0);
        check("abort_armed", int'(bus.armed), 1);
        send(5);
        check("abort_needs_crossing", int'(bus.write_enable), 0);

        // Full capture, then simultaneous idle and sample in WAIT.
        send(-2);
        send(2);
        check("second_trig_address", int'(bus.write_address), 'h100);
        repeat (N - 1) send(rand_sample());
        send_with_idle(-1);
        check("simul_read_index", int'(bus.read_index), 1);
        check("simul_no_write", int'(bus.write_enable), 0);
        send(1);
        check("simul_no_trigger", int'(bus.write_enable), 0);
        check("simul_armed", int'(bus.armed), 1);

        // Constant positive input from reset.
        do_reset();
        repeat (3) begin
            send(100);
            check("dc_early_no_write", int'(bus.write_enable), 0);
        end
        send(100);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        check("timeout_write_enable", int'(bus.write_enable), 1);
        check("timeout_address", int'(bus.write_address), 'h100);
        check("timeout_sample", int'(bus.write_sample), 'h80);
`else
        check("dc_no_write", int'(bus.write_enable), 0);
`endif

        // Randomized traffic with occasional idle and reset.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst                   = ($urandom_range(0, 599) == 0);
            bus.new_sample_ready  = ($urandom_range(0, 3) != 0);
            bus.wave_display_idle = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0)
                bus.new_sample_in = 16'(int'($urandom_range(0, 6)) - 3);
            else
                bus.new_sample_in = 16'(rand_sample());
        end
        @(negedge clk);
        rst                   = 1'b0;
        bus.new_sample_ready  = 1'b0;
        bus.wave_display_idle = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
